// File: rtl/aes_result_serializer_if.sv
// aes_result_serializer_if: ciphertext capture and 32-bit word stream bundle
//   slave  : serializer side (takes cipher_in/aes_done/m_ready/clear_ovf, drives stream and status)
//   master : producer/consumer side (the mirror image)
interface aes_result_serializer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic [127:0]     cipher_in;
  logic             aes_done;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [CNT_W-1:0] blocks_count;
  logic             full;
  logic             overflow;
  logic             clear_ovf;
  modport slave (
    input  cipher_in, aes_done, m_ready, clear_ovf,
    output m_data, m_valid, m_last, blocks_count, full, overflow
  );
  modport master (
    output cipher_in, aes_done, m_ready, clear_ovf,
    input  m_data, m_valid, m_last, blocks_count, full, overflow
  );
endinterface

// File: rtl/aes_result_serializer.sv
// aes_result_serializer: buffers 128-bit AES blocks in a FIFO and streams them as 32-bit words, MSW first
//   clk, reset : clock and asynchronous active-high reset
//   bus.slave  : cipher_in/aes_done capture, m_data/m_valid/m_ready/m_last stream,
//                blocks_count/full/overflow status, clear_ovf sticky-flag clear
module aes_result_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic                  clk,
  input logic                  reset,
  aes_result_serializer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [127:0]     mem [DEPTH];
  logic [127:0]     head;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       word_idx_q, word_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, done_q;
  logic             capture, xfer, pop, accept, drop;
  always_comb begin
    capture    = bus.aes_done & ~done_q;
    xfer       = bus.m_valid & bus.m_ready;
    pop        = xfer & (word_idx_q == 2'd3);
    // a final-word pop frees the head slot in the same cycle, so a full FIFO can still accept
    accept     = capture & (~bus.full | pop);
    drop       = capture & bus.full & ~pop;
    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    word_idx_d = xfer ? word_idx_q + 2'd1 : word_idx_q;
    count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
    ovf_d      = drop | (ovf_q & ~bus.clear_ovf);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      done_q     <= bus.aes_done;
    end
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr_q] <= bus.cipher_in;
  assign head             = mem[rd_ptr_q];
  assign bus.m_valid      = count_q != '0;
  assign bus.m_last       = bus.m_valid & (word_idx_q == 2'd3);
  assign bus.full         = count_q == CNT_W'(DEPTH);
  assign bus.blocks_count = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.m_data       = word_idx_q == 2'd0 ? head[127:96] :
                            word_idx_q == 2'd1 ? head[95:64]  :
                            word_idx_q == 2'd2 ? head[63:32]  : head[31:0];
endmodule

// File: tb/tb_aes_result_serializer.sv
// tb_aes_result_serializer: directed plus random stimulus against a block-queue reference model
module tb_aes_result_serializer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] q [$];
  int widx = 0;
  bit ovf = 0;
  bit prev = 0;
  aes_result_serializer_if #(.DEPTH(DEPTH)) bus ();
  aes_result_serializer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    widx = 0;
    ovf = 0;
    prev = 0;
  endtask
  task automatic tick();
    logic [127:0] h;
    bit was_full, xf, pp, cap, drop;
    chk("m_valid", bus.m_valid, q.size() != 0);
    chk("blocks_count", bus.blocks_count, q.size());
    chk("full", bus.full, q.size() == DEPTH);
    chk("overflow", bus.overflow, ovf);
    if (q.size() != 0) begin
      h = q[0];
      chk("m_data", bus.m_data, h[127-32*widx -: 32]);
      chk("m_last", bus.m_last, widx == 3);
    end else chk("m_last_idle", bus.m_last, 0);
    was_full = q.size() == DEPTH;
    xf = q.size() != 0 && bus.m_ready;
    pp = xf && widx == 3;
    cap = bus.aes_done && !prev;
    drop = cap && was_full && !pp;
    if (xf) widx = (widx + 1) % 4;
    if (pp) void'(q.pop_front());
    if (cap && !drop) q.push_back(bus.cipher_in);
    if (drop) ovf = 1;
    else if (bus.clear_ovf) ovf = 0;
    prev = bus.aes_done;
    @(posedge clk);
    #1;
  endtask
  task automatic cap_blk(input logic [127:0] d);
    bus.cipher_in = d;
    bus.aes_done = 1'b1;
    tick();
    bus.aes_done = 1'b0;
    tick();
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    bus.cipher_in = '0;
    bus.aes_done = 1'b0;
    bus.m_ready = 1'b0;
    bus.clear_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_last", bus.m_last, 0);
    chk("rst_count", bus.blocks_count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    reset = 1'b0;
    model_reset();
    // single block, known vector, drained at full rate
    bus.m_ready = 1'b1;
    bus.cipher_in = 128'h8EA2B7CA516745BFEAFC49904B496089;
    bus.aes_done = 1'b1;
    tick();
    bus.aes_done = 1'b0;
    chk("single_w0", bus.m_data, 32'h8EA2B7CA);
    chk("single_cnt", bus.blocks_count, 1);
    repeat (5) tick();
    chk("single_empty", bus.blocks_count, 0);
    // done held high captures once
    bus.m_ready = 1'b0;
    bus.cipher_in = rnd128();
    bus.aes_done = 1'b1;
    repeat (10) tick();
    bus.aes_done = 1'b0;
    chk("held_cnt", bus.blocks_count, 1);
    bus.m_ready = 1'b1;
    repeat (6) tick();
    // backpressure
    bus.m_ready = 1'b0;
    cap_blk(128'h00112233_44556677_8899AABB_CCDDEEFF);
    repeat (5) tick();
    chk("stall_w0", bus.m_data, 32'h00112233);
    for (int i = 0; i < 10; i++) begin
      bus.m_ready = i[0] ? 1'b0 : 1'b1;
      tick();
    end
    chk("bp_empty", bus.blocks_count, 0);
    // fill, overflow, set-wins-over-clear, then clear
    bus.m_ready = 1'b0;
    repeat (4) cap_blk(rnd128());
    chk("fill_full", bus.full, 1);
    chk("fill_cnt", bus.blocks_count, 4);
    cap_blk(rnd128());
    chk("ovf_set", bus.overflow, 1);
    bus.cipher_in = rnd128();
    bus.aes_done = 1'b1;
    bus.clear_ovf = 1'b1;
    tick();
    bus.aes_done = 1'b0;
    bus.clear_ovf = 1'b0;
    tick();
    chk("ovf_set_wins", bus.overflow, 1);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    chk("ovf_cleared", bus.overflow, 0);
    bus.m_ready = 1'b1;
    repeat (4 * DEPTH + 2) tick();
    // capture coincides with the final-word pop of a full FIFO
    bus.m_ready = 1'b0;
    repeat (4) cap_blk(rnd128());
    bus.m_ready = 1'b1;
    repeat (3) tick();
    bus.cipher_in = rnd128();
    bus.aes_done = 1'b1;
    tick();
    bus.aes_done = 1'b0;
    chk("simul_cnt", bus.blocks_count, 4);
    chk("simul_ovf", bus.overflow, 0);
    repeat (4 * DEPTH + 2) tick();
    // random traffic, first congested then mostly flowing
    for (int i = 0; i < 400; i++) begin
      bus.aes_done = $urandom_range(0, 3) == 0;
      bus.cipher_in = rnd128();
      bus.m_ready = i < 200 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      bus.clear_ovf = $urandom_range(0, 15) == 0;
      tick();
    end
    bus.aes_done = 1'b0;
    bus.clear_ovf = 1'b0;
    bus.m_ready = 1'b1;
    repeat (4 * DEPTH + 2) tick();
    // async reset after two words of a block
    bus.cipher_in = rnd128();
    bus.aes_done = 1'b1;
    tick();
    bus.aes_done = 1'b0;
    repeat (2) tick();
    #3;
    reset = 1'b1;
    #1;
    chk("arst_valid", bus.m_valid, 0);
    chk("arst_cnt", bus.blocks_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.m_ready = 1'b0;
    cap_blk(128'hCAFEBABE_01234567_89ABCDEF_DEADBEEF);
    chk("post_rst_w0", bus.m_data, 32'hCAFEBABE);
    bus.m_ready = 1'b1;
    repeat (6) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
